// File: rtl/rx_deframer_pkg.sv
// Shared types and constants for the Rx frame deframer.
package rx_deframer_pkg;

   typedef enum logic {
      ST_HUNT    = 1'b0,
      ST_PAYLOAD = 1'b1
   } state_e;

   localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACFFC1D;

   // Width needed to hold a Hamming distance in the range 0..sync_len.
   function automatic int unsigned dist_width(input int unsigned sync_len);
      return $clog2(sync_len + 1);
   endfunction

   localparam int unsigned DEFAULT_DIST_W = dist_width(32);

endpackage

// File: rtl/sync_correlator.sv
// Combinational Hamming-distance correlator of a candidate window against the sync word,
// for both the normal and the bit-inverted polarity.
module sync_correlator
   import rx_deframer_pkg::*;
#(
   parameter int unsigned SYNC_LEN  = 32,
   parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD,
   parameter int unsigned MAX_ERR   = 2,
   parameter int unsigned DIST_W    = dist_width(SYNC_LEN)
) (
   input  logic [SYNC_LEN-1:0] sr_next,
   output logic [DIST_W-1:0]   distance_norm,
   output logic [DIST_W-1:0]   distance_inv,
   output logic                match_norm,
   output logic                match_inv
);

   localparam logic [SYNC_LEN-1:0] SyncPat = SYNC_WORD[SYNC_LEN-1:0];

   always_comb begin
      distance_norm = '0;
      distance_inv  = '0;
      for (int i = 0; i < SYNC_LEN; i++) begin
         distance_norm = distance_norm + DIST_W'(sr_next[i] ^ SyncPat[i]);
         distance_inv  = distance_inv + DIST_W'(~sr_next[i] ^ SyncPat[i]);
      end
   end

   assign match_norm = (32'(distance_norm) <= MAX_ERR);
   assign match_inv  = (32'(distance_inv) <= MAX_ERR);

endmodule

// File: rtl/rx_frame_deframer.sv
// Rx deframer: hunts for the sync word in the recovered bit stream and emits the payload as bytes.
// Define RX_DEFRAMER_POLARITY_FIX_EN to also lock on an inverted sync and de-invert the payload.
module rx_frame_deframer
   import rx_deframer_pkg::*;
#(
   parameter int unsigned SYNC_LEN      = 32,
   parameter logic [31:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
   parameter int unsigned MAX_ERR       = 2,
   parameter int unsigned PAYLOAD_BYTES = 4
) (
   input  logic        clk_32M768,
   input  logic        rst_n_32M768,
   input  logic        enable,
   input  logic        rx_bit,
   input  logic        rx_bit_valid,
   output logic [7:0]  data_tdata,
   output logic        data_tvalid,
   output logic        data_tuser,
   output logic        data_tlast,
   output logic        locked,
   output logic        polarity_inv,
   output logic        frame_abort,
   output logic [15:0] frame_cnt
);

   localparam int unsigned DistW    = dist_width(SYNC_LEN);
   localparam logic [7:0]  LastByte = 8'(PAYLOAD_BYTES - 1);

   state_e              state_q, state_d;
   logic [SYNC_LEN-1:0] sr_q, sr_d, sr_next;
   logic [7:0]          byte_q, byte_d, byte_next;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [7:0]          byte_cnt_q, byte_cnt_d;
   logic                pol_q, pol_d;
   logic [7:0]          tdata_q, tdata_d;
   logic                tvalid_q, tvalid_d;
   logic                tuser_q, tuser_d;
   logic                tlast_q, tlast_d;
   logic                abort_q, abort_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;

   logic [DistW-1:0]    distance_norm, distance_inv;
   logic                match_norm, match_inv;

   assign sr_next   = {sr_q[SYNC_LEN-2:0], rx_bit};
   assign byte_next = {byte_q[6:0], rx_bit ^ pol_q};

   sync_correlator #(
      .SYNC_LEN  (SYNC_LEN),
      .SYNC_WORD (SYNC_WORD),
      .MAX_ERR   (MAX_ERR),
      .DIST_W    (DistW)
   ) u_sync_correlator (
      .sr_next       (sr_next),
      .distance_norm (distance_norm),
      .distance_inv  (distance_inv),
      .match_norm    (match_norm),
      .match_inv     (match_inv)
   );

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      byte_d      = byte_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      pol_d       = pol_q;
      tdata_d     = tdata_q;
      tvalid_d    = 1'b0;
      tuser_d     = 1'b0;
      tlast_d     = 1'b0;
      abort_d     = 1'b0;
      frame_cnt_d = frame_cnt_q;

      unique case (state_q)
         ST_HUNT: begin
            if (!enable) begin
               sr_d = '0;
            end else if (rx_bit_valid) begin
               sr_d = sr_next;
               if (match_norm) begin
                  state_d    = ST_PAYLOAD;
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
                  pol_d      = 1'b0;
`ifdef RX_DEFRAMER_POLARITY_FIX_EN
               end else if (match_inv) begin
                  state_d    = ST_PAYLOAD;
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
                  pol_d      = 1'b1;
`endif
               end
            end
         end

         ST_PAYLOAD: begin
            if (!enable) begin
               // Drop the partial frame; the sync hunt restarts from an empty window.
               state_d   = ST_HUNT;
               sr_d      = '0;
               pol_d     = 1'b0;
               bit_cnt_d = '0;
               abort_d   = 1'b1;
            end else if (rx_bit_valid) begin
               byte_d    = byte_next;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  tdata_d    = byte_next;
                  tvalid_d   = 1'b1;
                  tuser_d    = (byte_cnt_q == 8'd0);
                  tlast_d    = (byte_cnt_q == LastByte);
                  byte_cnt_d = byte_cnt_q + 8'd1;
                  if (byte_cnt_q == LastByte) begin
                     state_d     = ST_HUNT;
                     sr_d        = '0;
                     pol_d       = 1'b0;
                     frame_cnt_d = frame_cnt_q + 16'd1;
                  end
               end
            end
         end

         default: state_d = ST_HUNT;
      endcase
   end

   always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
      if (!rst_n_32M768) begin
         state_q     <= ST_HUNT;
         sr_q        <= '0;
         byte_q      <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         pol_q       <= 1'b0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tuser_q     <= 1'b0;
         tlast_q     <= 1'b0;
         abort_q     <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         byte_q      <= byte_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         pol_q       <= pol_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tuser_q     <= tuser_d;
         tlast_q     <= tlast_d;
         abort_q     <= abort_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign data_tdata   = tdata_q;
   assign data_tvalid  = tvalid_q;
   assign data_tuser   = tuser_q;
   assign data_tlast   = tlast_q;
   assign locked       = (state_q == ST_PAYLOAD);
   assign polarity_inv = pol_q;
   assign frame_abort  = abort_q;
   assign frame_cnt    = frame_cnt_q;

   // Distances are exported by the correlator for observability only.
   logic unused_corr;
`ifdef RX_DEFRAMER_POLARITY_FIX_EN
   assign unused_corr = ^{distance_norm, distance_inv};
`else
   assign unused_corr = ^{distance_norm, distance_inv, match_inv};
`endif

endmodule

// File: tb/tb_rx_frame_deframer.sv
// Scoreboard bench for rx_frame_deframer: stimulus pushes expected bytes, a forked monitor checks them.
module tb_rx_frame_deframer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        rx_bit = 1'b0;
   logic        rx_bit_valid = 1'b0;
   logic [7:0]  data_tdata;
   logic        data_tvalid, data_tuser, data_tlast;
   logic        locked, polarity_inv, frame_abort;
   logic [15:0] frame_cnt;

   typedef struct packed {
      logic [7:0] d;
      logic       u;
      logic       l;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          exp_cnt = 0;
   logic        gap = 1'b0;

   localparam logic [31:0] Sync = 32'h1ACFFC1D;

   rx_frame_deframer dut (
      .clk_32M768   (clk),
      .rst_n_32M768 (rst_n),
      .enable       (enable),
      .rx_bit       (rx_bit),
      .rx_bit_valid (rx_bit_valid),
      .data_tdata   (data_tdata),
      .data_tvalid  (data_tvalid),
      .data_tuser   (data_tuser),
      .data_tlast   (data_tlast),
      .locked       (locked),
      .polarity_inv (polarity_inv),
      .frame_abort  (frame_abort),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (data_tvalid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %h required none at %0t", data_tdata, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("stream_byte", {22'd0, data_tdata, data_tuser, data_tlast},
                     {22'd0, e.d, e.u, e.l});
            end
         end else begin
            check("idle_qualifiers", {30'd0, data_tuser, data_tlast}, 32'd0);
         end
      end
   endtask

   task automatic send_bit(input logic b);
      rx_bit       = b;
      rx_bit_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_bit_valid = 1'b0;
      rx_bit       = 1'b0;
      if (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic push_frame(input logic [31:0] p);
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         e.d = p[31-8*k -: 8];
         e.u = (k == 0);
         e.l = (k == 3);
         exp_q.push_back(e);
      end
   endtask

   // Sync then four payload bytes; expectations are pushed before the bits go in.
   task automatic clean_frame(input logic [31:0] sync_bits, input logic [31:0] payload);
      push_frame(payload);
      send_word(sync_bits, 32);
      check("locked_after_sync", {31'd0, locked}, 32'd1);
      check("pol_normal", {31'd0, polarity_inv}, 32'd0);
      send_word(payload, 32);
      exp_cnt = (exp_cnt + 1) % 65536;
      check("frame_cnt", {16'd0, frame_cnt}, exp_cnt);
      check("unlocked_after_frame", {31'd0, locked}, 32'd0);
   endtask

   initial begin
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("reset_stream", {22'd0, data_tdata, data_tvalid, data_tuser}, 32'd0);
      check("reset_status", {29'd0, locked, polarity_inv, frame_abort}, 32'd0);
      check("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;
      @(posedge clk);
      #1;

      // Noise prefix then a clean frame.
      send_word(32'h0000_034B, 10);
      check("no_lock_on_noise", {31'd0, locked}, 32'd0);
      clean_frame(Sync, 32'hA53C00FF);

      // Two sync bit errors still lock; bits spaced by idle cycles.
      gap = 1'b1;
      clean_frame(Sync ^ 32'h0001_0100, 32'h12345678);
      gap = 1'b0;

      // Three sync bit errors must not lock.
      send_word(Sync ^ 32'h8000_0101, 32);
      check("no_lock_3err", {31'd0, locked}, 32'd0);
      send_word(32'h0, 16);
      check("still_unlocked_3err", {31'd0, locked}, 32'd0);

      // Fully inverted frame.
`ifdef RX_DEFRAMER_POLARITY_FIX_EN
      push_frame(32'hA53C00FF);
      send_word(~Sync, 32);
      check("locked_inv", {31'd0, locked}, 32'd1);
      check("pol_inverted", {31'd0, polarity_inv}, 32'd1);
      send_word(~32'hA53C00FF, 32);
      exp_cnt++;
      check("frame_cnt_inv", {16'd0, frame_cnt}, exp_cnt);
      check("pol_cleared", {31'd0, polarity_inv}, 32'd0);
`else
      send_word(~Sync, 32);
      check("no_lock_inv", {31'd0, locked}, 32'd0);
      send_word(~32'hA53C00FF, 32);
      check("frame_cnt_inv", {16'd0, frame_cnt}, exp_cnt);
      check("pol_tied", {31'd0, polarity_inv}, 32'd0);
`endif
      send_word(32'h0, 32);

      // Abort after two payload bytes plus a partial third.
      exp_q.push_back('{d: 8'hAA, u: 1'b1, l: 1'b0});
      exp_q.push_back('{d: 8'h55, u: 1'b0, l: 1'b0});
      send_word(Sync, 32);
      send_word(32'h0000AA55, 16);
      send_word(32'h5, 3);
      check("no_abort_yet", {31'd0, frame_abort}, 32'd0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("abort_pulse", {30'd0, frame_abort, locked}, 32'd2);
      @(posedge clk);
      #1;
      check("abort_one_cycle", {31'd0, frame_abort}, 32'd0);
      check("frame_cnt_abort", {16'd0, frame_cnt}, exp_cnt);
      send_word(Sync, 32);
      check("no_lock_disabled", {31'd0, locked}, 32'd0);
      enable = 1'b1;
      clean_frame(Sync, 32'h01020304);

      // Counter wrap, with the sync pattern carried as payload, then a back-to-back frame.
      dut.frame_cnt_q = 16'hFFFF;
      #1;
      check("preload", {16'd0, frame_cnt}, 32'h0000FFFF);
      exp_cnt = 16'hFFFF;
      clean_frame(Sync, Sync);
      check("wrap_zero", {16'd0, frame_cnt}, 32'd0);
      clean_frame(Sync, 32'hDEADBEEF);

      // Reset in the middle of a payload.
      exp_q.push_back('{d: 8'h77, u: 1'b1, l: 1'b0});
      send_word(Sync, 32);
      send_word(32'h0000_0077, 8);
      send_word(32'h9, 4);
      rst_n = 1'b0;
      #1;
      check("rst_stream", {22'd0, data_tdata, data_tvalid, data_tuser}, 32'd0);
      check("rst_status", {28'd0, data_tlast, locked, polarity_inv, frame_abort}, 32'd0);
      check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      clean_frame(Sync, 32'hC35A0FF0);

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rx_frame_deframer.md
Name: rx_frame_deframer

Overview:
- Receive-side counterpart of the Tx framer.
- Takes the recovered serial bit stream (Rx_1bit with its valid strobe) and hunts for the frame sync word.
- Reassembles each payload MSB-first into bytes and emits them on the data_tdata/tvalid/tuser/tlast stream, matching the byte stream the Tx side consumes.
- Sits after Rx symbol decision, in the clk_32M768 domain; bits arrive as single-cycle strobes at ~1.024 Mb/s.

Parameters:
- SYNC_LEN, 32, sync word length in bits (8..32).
- SYNC_WORD, 32'h1ACFFC1D, sync pattern; low SYNC_LEN bits used, MSB received first.
- MAX_ERR, 2, maximum Hamming distance accepted as a sync match; must be < SYNC_LEN/2.
- PAYLOAD_BYTES, 4, bytes per frame (1..255).

Ports:
- clk_32M768  in  1  system clock.
- rst_n_32M768  in  1  asynchronous active-low reset.
- enable  in  1  deframer enable; low forces HUNT.
- rx_bit  in  1  recovered bit.
- rx_bit_valid  in  1  single-cycle strobe; each high cycle is one bit.
- data_tdata  out  8  payload byte.
- data_tvalid  out  1  one-cycle byte strobe; no backpressure.
- data_tuser  out  1  high with the first byte of a frame.
- data_tlast  out  1  high with the last byte of a frame.
- locked  out  1  high while in PAYLOAD.
- polarity_inv  out  1  frame was found with inverted sync.
- frame_abort  out  1  one-cycle pulse when a frame in progress is dropped.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF -> 0.

Behaviour:
- Reset values: all outputs 0, state HUNT, shift register 0, counters 0.
- States: HUNT, PAYLOAD.
- HUNT shift register: on rx_bit_valid, sr <= {sr[SYNC_LEN-2:0], rx_bit}.
- HUNT match: distance = popcount(sr_next ^ SYNC_WORD), evaluated on the post-shift value. If distance <= MAX_ERR, go to PAYLOAD on that edge with bit_cnt=0, byte_cnt=0, polarity_inv=0.
- PAYLOAD: each strobe shifts (rx_bit ^ polarity_inv) into the byte register. On the 8th bit, on the next edge:
  - data_tdata = byte, data_tvalid = 1 for exactly one cycle.
  - data_tuser = (byte_cnt == 0).
  - data_tlast = (byte_cnt == PAYLOAD_BYTES-1).
  - data_tuser and data_tlast are valid only with data_tvalid and are 0 otherwise.
- Latency: one clk_32M768 cycle from the strobe carrying bit 8 to data_tvalid.
- PAYLOAD_BYTES=1: data_tuser and data_tlast are both high on the single byte.
- Frame end: on the edge emitting data_tlast, frame_cnt increments, state returns to HUNT, and sr clears to 0. A new sync therefore needs a full SYNC_LEN fresh bits; payload bits are never reused for sync.
- enable low:
  - In HUNT: sr held at 0.
  - In PAYLOAD: partial byte discarded, no tlast, frame_abort pulses one cycle, return to HUNT, frame_cnt unchanged.
- Reset mid-frame: immediate return to reset values, with no abort pulse.
- rx_bit_valid high for consecutive cycles: each cycle counts as a separate bit.
- locked = (state == PAYLOAD).

Optional Feature:
- Macro: RX_DEFRAMER_POLARITY_FIX_EN. Resolves the Costas-loop 180° ambiguity.
- When defined:
  - HUNT also tests popcount(~sr_next ^ SYNC_WORD) <= MAX_ERR.
  - The normal match has priority.
  - On an inverted match, polarity_inv=1 for the frame, so payload bits are inverted before assembly.
  - polarity_inv clears on return to HUNT.
- When undefined: only the normal comparison exists and polarity_inv is tied 0.

Decomposition:
- Package rx_deframer_pkg:
  - state encoding constants ST_HUNT / ST_PAYLOAD;
  - default sync word constant;
  - helper constant for distance width = clog2(SYNC_LEN+1).
- One sub-module, sync_correlator: combinational popcount of (sr_next ^ SYNC_WORD) and of its inverse. Outputs distance_norm and distance_inv plus match flags against MAX_ERR.

Test Plan:
- Clean frame: 10 random bits, then 0x1ACFFC1D, then payload A5 3C 00 FF -> four tvalid pulses with those bytes; tuser only on A5, tlast only on FF; frame_cnt=1, locked low afterwards.
- Sync errors: sync with 2 flipped bits -> frame decoded; sync with 3 flipped bits -> no tvalid, locked stays 0.
- Inverted stream: entire frame bit-inverted.
  - Macro on: bytes A5 3C 00 FF out, polarity_inv=1.
  - Macro off: no output.
- Abort: enable dropped after 2 payload bytes -> frame_abort pulse, no tlast, frame_cnt unchanged; next clean frame decodes normally.
- Back-to-back frames with frame_cnt preloaded by running 65535 frames (or forced) -> frame_cnt wraps to 0; sync pattern embedded inside payload bytes does not retrigger mid-frame.
- rst_n_32M768 asserted mid-payload -> all outputs 0 immediately; following frame decodes correctly.
